// File: rtl/arch_state_if.sv
// Writeback/decode-facing bus of the PikaRISC architectural state block.
// master = pipeline side (writeback + decode), slave = arch_state.
interface arch_state_if;
    logic        reg_write_en;
    logic [3:0]  reg_num;
    logic [31:0] reg_val;
    logic        pc_write_en;
    logic [31:0] pc_in;
    logic        cpsr_write_en;
    logic [31:0] cpsr_in;
    logic        pc_advance;
    logic [3:0]  rs_num;
    logic [3:0]  rt_num;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_busy;
    logic        rt_busy;
    logic        sb_set_en;
    logic [3:0]  sb_set_num;
    logic        sb_cpsr_set;
    logic        cpsr_busy;
    logic        flush;
    logic [31:0] pc_out;
    logic [31:0] cpsr_out;
    logic [31:0] retire_cnt;

    modport master (
        output reg_write_en, reg_num, reg_val, pc_write_en, pc_in,
               cpsr_write_en, cpsr_in, pc_advance, rs_num, rt_num,
               sb_set_en, sb_set_num, sb_cpsr_set, flush,
        input  rs_val, rt_val, rs_busy, rt_busy, cpsr_busy,
               pc_out, cpsr_out, retire_cnt
    );

    modport slave (
        input  reg_write_en, reg_num, reg_val, pc_write_en, pc_in,
               cpsr_write_en, cpsr_in, pc_advance, rs_num, rt_num,
               sb_set_en, sb_set_num, sb_cpsr_set, flush,
        output rs_val, rt_val, rs_busy, rt_busy, cpsr_busy,
               pc_out, cpsr_out, retire_cnt
    );
endinterface

// File: rtl/arch_state.sv
// PikaRISC architectural state: 16x32 GPR file with bypassed read ports,
// PC, CPSR, pending-write scoreboard and a retire counter.
module arch_state #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    arch_state_if.slave bus
);

    logic [31:0] gpr [16];
    logic [31:0] pc_q;
    logic [31:0] cpsr_q;
    logic [15:0] sb_q;
    logic [15:0] sb_d;
    logic        cpsr_pend_q;
    logic        cpsr_pend_d;
    logic [31:0] retire_q;
    logic        rs_hit;
    logic        rt_hit;
    logic        any_write;

    assign rs_hit    = bus.reg_write_en && (bus.reg_num == bus.rs_num);
    assign rt_hit    = bus.reg_write_en && (bus.reg_num == bus.rt_num);
    assign any_write = bus.reg_write_en || bus.pc_write_en || bus.cpsr_write_en;

    // Order matters: clear, then set (newer producer wins), then flush over all.
    always_comb begin
        sb_d = sb_q;
        if (bus.reg_write_en) sb_d[bus.reg_num] = 1'b0;
        if (bus.sb_set_en)    sb_d[bus.sb_set_num] = 1'b1;
        if (bus.flush)        sb_d = '0;

        cpsr_pend_d = cpsr_pend_q;
        if (bus.cpsr_write_en) cpsr_pend_d = 1'b0;
        if (bus.sb_cpsr_set)   cpsr_pend_d = 1'b1;
        if (bus.flush)         cpsr_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) gpr[i] <= '0;
        end else if (bus.reg_write_en) begin
            gpr[bus.reg_num] <= bus.reg_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            cpsr_q      <= '0;
            sb_q        <= '0;
            cpsr_pend_q <= 1'b0;
            retire_q    <= '0;
        end else begin
            if (bus.pc_write_en)     pc_q <= bus.pc_in;
            else if (bus.pc_advance) pc_q <= pc_q + PC_STEP;
            if (bus.cpsr_write_en)   cpsr_q <= bus.cpsr_in;
            sb_q        <= sb_d;
            cpsr_pend_q <= cpsr_pend_d;
            if (any_write)           retire_q <= retire_q + 32'd1;
        end
    end

    always_comb begin
        bus.rs_val     = rs_hit ? bus.reg_val : gpr[bus.rs_num];
        bus.rt_val     = rt_hit ? bus.reg_val : gpr[bus.rt_num];
        bus.rs_busy    = sb_q[bus.rs_num] && !rs_hit;
        bus.rt_busy    = sb_q[bus.rt_num] && !rt_hit;
        bus.cpsr_busy  = cpsr_pend_q && !bus.cpsr_write_en;
        bus.pc_out     = pc_q;
        bus.cpsr_out   = cpsr_q;
        bus.retire_cnt = retire_q;
    end

endmodule

// File: doc/arch_state.md
# arch_state

Architectural state holder for the PikaRISC core: the 16×32 general-purpose register file, the program counter and the CPSR. It sits at the receiving end of the writeback stage's `reg_*`, `pc_*` and `cpsr_*` write buses. It serves operands to decode through two bypassed read ports and runs a pending-write scoreboard so decode can detect read-after-write hazards. It also keeps a free-running retire counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `PC_STEP`, 32'd4: PC increment per `pc_advance`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `reg_write_en` in 1: GPR write strobe from writeback.
- `reg_num` in 4: GPR write index.
- `reg_val` in 32: GPR write data.
- `pc_write_en` in 1: PC write strobe (taken branch).
- `pc_in` in 32: PC write data.
- `cpsr_write_en` in 1: CPSR write strobe.
- `cpsr_in` in 32: CPSR write data.
- `pc_advance` in 1: fetch consumed an instruction; step the PC.
- `rs_num`, `rt_num` in 4 each: read port indices.
- `rs_val`, `rt_val` out 32 each: read data, combinational.
- `rs_busy`, `rt_busy` out 1 each: the indexed GPR has a pending write.
- `sb_set_en` in 1: decode issued an instruction writing a GPR.
- `sb_set_num` in 4: index of that GPR.
- `sb_cpsr_set` in 1: decode issued a CPSR-writing instruction.
- `cpsr_busy` out 1: a CPSR write is pending.
- `flush` in 1: pipeline flush; clears all pending bits.
- `pc_out` out 32: current PC.
- `cpsr_out` out 32: current CPSR.
- `retire_cnt` out 32: count of writeback events.

## Operation
- **Reset (async, `rst_n`=0):**
  - All 16 GPRs = 0, `pc_out` = `RESET_PC`, `cpsr_out` = 0.
  - Scoreboard bits = 0, `cpsr_busy` = 0, `retire_cnt` = 0.
  - Applies immediately; any write in flight that cycle is discarded.
- **GPR write:** on an edge with `reg_write_en`=1, `gpr[reg_num]` <= `reg_val`. All 16 indices are writable; index 15 is an ordinary GPR, not the PC.
- **Read ports:** `rs_val` = `gpr[rs_num]`, except when `reg_write_en`=1 and `reg_num`==`rs_num`, in which case `rs_val` = `reg_val` (write-through bypass). `rt_val` behaves identically. Both ports may read the same index.
- **PC:**
  - Priority is `pc_write_en` > `pc_advance`.
  - `pc_write_en`=1: `pc` <= `pc_in`, and `pc_advance` is ignored that cycle.
  - Otherwise, `pc_advance`=1: `pc` <= `pc` + `PC_STEP`, modulo 2^32 (wraps, no flag).
  - Otherwise `pc` holds.
- **CPSR:** `cpsr_write_en`=1: `cpsr` <= `cpsr_in`. All 32 bits are stored; no field masking.
- **Independent enables:** the three write enables are independent. Any combination asserted in one cycle all commit on that edge.
- **Scoreboard (16 pending bits `sb[i]`):**
  - Set: `sb_set_en` sets `sb[sb_set_num]`.
  - Clear: `reg_write_en` clears `sb[reg_num]`.
  - Same index set and cleared in the same cycle: the set wins and the bit stays 1 (newer producer).
  - `flush`=1: all bits cleared, overriding sets in the same cycle.
  - `rs_busy` = `sb[rs_num]` & ~(`reg_write_en` & `reg_num`==`rs_num`). The bypass makes a write landing this cycle not busy. `rt_busy` is analogous.
- **CPSR pending bit:**
  - `sb_cpsr_set` sets it; `cpsr_write_en` clears it; a simultaneous set and clear leaves it set; `flush` clears it.
  - `cpsr_busy` = pending & ~`cpsr_write_en`.
- **Retire counter:** `retire_cnt` increments by 1 on each edge where any of `reg_write_en`, `pc_write_en`, `cpsr_write_en` is 1. It counts once per cycle, not per enable, and wraps 0xFFFF_FFFF -> 0.

## Timing
- Writes commit at the rising edge where the enable is sampled. The new value is visible on registered state (`pc_out`, `cpsr_out`, storage) from the next cycle.
- GPR reads have zero-cycle write-to-read latency via the bypass.
- `pc_out` and `cpsr_out` are registered with no bypass: a same-cycle write shows one cycle later.
- Scoreboard set at edge N: busy is visible from cycle N+1. A clearing write in cycle M deasserts busy combinationally in cycle M.
- No handshakes: every input is sampled every cycle, and the block never stalls.
- Reset deassertion: the first edge with `rst_n`=1 may already perform writes.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run after writing r3=0x55 and PC=0x100. Required: `pc_out`=`RESET_PC`, reading r3 gives 0, `cpsr_out`=0, `retire_cnt`=0, with no clock edge needed.
- **Bypass:** `reg_write_en`=1, `reg_num`=5, `reg_val`=0xDEADBEEF, `rs_num`=`rt_num`=5 in the same cycle. Required: both read ports show 0xDEADBEEF that cycle, and r5 holds it afterwards.
- **PC priority:**
  - PC=0x10 with `pc_advance`=1 and `pc_write_en`=1, `pc_in`=0x200. Required: next `pc_out`=0x200.
  - Then `pc_advance` only. Required: 0x204.
  - From PC=0xFFFF_FFFC, advance. Required: 0x0.
- **Scoreboard:**
  - `sb_set_en` r7. Required: next cycle `rs_busy`=1 with `rs_num`=7.
  - Writeback to r7 while `sb_set_en` r7 is asserted again. Required: bit stays set.
  - Plain writeback to r7. Required: `rs_busy`=0 in that same cycle.
  - `flush` with r2 and CPSR pending. Required: all busy outputs 0.
- **Combined writes / counter:** all three enables asserted in one cycle. Required: r1, PC and CPSR all update, and `retire_cnt` increases by exactly 1. Preload 0xFFFF_FFFF and write once. Required: `retire_cnt` = 0.
